// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared definitions for the smiley collision logic.
//   EDGE_LEFT/TOP/RIGHT/BOTTOM : bit positions inside a 4-bit edge code; the
//                                motion controller decodes HitEdgeCode with
//                                the same indices.
//   state_t                    : collision_detector FSM states.
// -----------------------------------------------------------------------------
package collision_pkg;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_W      = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/collision_detector_edge_classifier.sv
// -----------------------------------------------------------------------------
// edge_classifier
// Pure combinational map from a pixel offset inside a sprite to the sprite
// edge band(s) that pixel lies in. Corner pixels set two bits, interior
// pixels set none.
// Ports:
//   offsetX [10:0] in  : column inside the sprite (0..SPRITE_W-1)
//   offsetY [10:0] in  : row inside the sprite (0..SPRITE_H-1)
//   edges   [3:0]  out : {left, top, right, bottom}
// -----------------------------------------------------------------------------
module edge_classifier
    import collision_pkg::*;
#(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int EDGE_MARGIN = 4
) (
    input  logic [10:0]       offsetX,
    input  logic [10:0]       offsetY,
    output logic [EDGE_W-1:0] edges
);

    localparam logic [10:0] LOW_LIM    = 11'(EDGE_MARGIN);
    localparam logic [10:0] RIGHT_LIM  = 11'(SPRITE_W - EDGE_MARGIN);
    localparam logic [10:0] BOTTOM_LIM = 11'(SPRITE_H - EDGE_MARGIN);

    always_comb begin
        edges              = '0;
        edges[EDGE_LEFT]   = (offsetX <  LOW_LIM);
        edges[EDGE_TOP]    = (offsetY <  LOW_LIM);
        edges[EDGE_RIGHT]  = (offsetX >= RIGHT_LIM);
        edges[EDGE_BOTTOM] = (offsetY >= BOTTOM_LIM);
    end

endmodule

// File: rtl/collision_detector.sv
// -----------------------------------------------------------------------------
// collision_detector
// Accumulates smiley/border and smiley/flipper overlaps over one video frame
// and reports them at the next startOfFrame as single-cycle pulses, together
// with a held code of the smiley edges that touched a border.
//
// Optional build macro: COLLISION_HOLDOFF_EN
//   When defined, a border report arms a frame counter (HOLDOFF_FRAMES) that
//   suppresses border reports on the following frames. Flipper reports are
//   never suppressed.
//
// Ports:
//   clk, resetN                 : clock, asynchronous active-low reset
//   startOfFrame                : one-cycle pulse at frame start
//   pause                       : freezes detection (accumulators held clear)
//   smileyDR/bordersDR/flipperDR: per-pixel draw requests
//   offsetX, offsetY            : pixel position inside the smiley sprite
//   collisionSmileyBorders      : one-cycle pulse, border overlap last frame
//   collisionSmileyFlipper      : one-cycle pulse, flipper overlap last frame
//   HitEdgeCode                 : {left,top,right,bottom}, held until the
//                                 next border report
//
// Timing: pulses are registered at the startOfFrame edge, so they are high
// for exactly the REPORT cycle that follows startOfFrame.
// -----------------------------------------------------------------------------
module collision_detector
    import collision_pkg::*;
#(
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 32,
    parameter int EDGE_MARGIN    = 4,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              pause,
    input  logic              smileyDR,
    input  logic              bordersDR,
    input  logic              flipperDR,
    input  logic [10:0]       offsetX,
    input  logic [10:0]       offsetY,
    output logic              collisionSmileyBorders,
    output logic              collisionSmileyFlipper,
    output logic [EDGE_W-1:0] HitEdgeCode
);

    state_t            state;
    logic              accBorder;
    logic              accFlipper;
    logic [EDGE_W-1:0] accEdge;
    logic [EDGE_W-1:0] pixEdges;
    logic              borderHit;
    logic              flipperHit;
    logic              frameEnd;
    logic              suppress;
    logic              borderFire;

    edge_classifier #(
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .EDGE_MARGIN (EDGE_MARGIN)
    ) u_edge_classifier (
        .offsetX (offsetX),
        .offsetY (offsetY),
        .edges   (pixEdges)
    );

    assign borderHit  = smileyDR & bordersDR;
    assign flipperHit = smileyDR & flipperDR;
    // startOfFrame only closes a frame from ACCUM and while running.
    assign frameEnd   = (state == ACCUM) & startOfFrame & ~pause;

`ifdef COLLISION_HOLDOFF_EN
    logic [3:0] holdoffCnt;

    assign suppress = (holdoffCnt != 4'd0);

    // Decrement only on frame ends after the one that loaded the counter;
    // a pause freezes it because frameEnd cannot occur while paused.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            holdoffCnt <= 4'd0;
        end else if (frameEnd) begin
            if (holdoffCnt != 4'd0)
                holdoffCnt <= holdoffCnt - 4'd1;
            else if (accBorder)
                holdoffCnt <= 4'(HOLDOFF_FRAMES);
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign borderFire = accBorder & ~suppress;

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                  <= ACCUM;
            collisionSmileyBorders <= 1'b0;
            collisionSmileyFlipper <= 1'b0;
            HitEdgeCode            <= '0;
        end else begin
            collisionSmileyBorders <= 1'b0;
            collisionSmileyFlipper <= 1'b0;
            case (state)
                ACCUM: begin
                    if (frameEnd) begin
                        collisionSmileyBorders <= borderFire;
                        collisionSmileyFlipper <= accFlipper;
                        if (borderFire)
                            HitEdgeCode <= accEdge;
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    state <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    // Frame accumulators. On a frame end the snapshot has already been taken
    // above, so the accumulators restart from the current pixel: an overlap
    // coincident with startOfFrame belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            accBorder  <= 1'b0;
            accFlipper <= 1'b0;
            accEdge    <= '0;
        end else if (pause) begin
            accBorder  <= 1'b0;
            accFlipper <= 1'b0;
            accEdge    <= '0;
        end else if (frameEnd) begin
            accBorder  <= borderHit;
            accFlipper <= flipperHit;
            accEdge    <= borderHit ? pixEdges : '0;
        end else begin
            if (borderHit) begin
                accBorder <= 1'b1;
                accEdge   <= accEdge | pixEdges;
            end
            if (flipperHit)
                accFlipper <= 1'b1;
        end
    end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Sits directly upstream of the smiley motion controller.
- Per pixel, it watches the smiley, border and flipper draw requests, plus the pixel's offset inside the smiley sprite.
- It accumulates overlaps over one video frame and classifies which sprite edge(s) touched.
- At frame boundary it issues single-cycle collision pulses with a held HitEdgeCode. The controller therefore sees at most one border event and one flipper event per frame.

Parameters:
- SPRITE_W, 32, smiley sprite width in pixels
- SPRITE_H, 32, smiley sprite height in pixels
- EDGE_MARGIN, 4, width in pixels of each edge-classification band
- HOLDOFF_FRAMES, 2, frames of border-report suppression after a report (used only with the optional feature)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- pause  in  1  freezes detection
- smileyDR  in  1  smiley drawing request for current pixel
- bordersDR  in  1  borders drawing request for current pixel
- flipperDR  in  1  flipper drawing request for current pixel
- offsetX  in  11  pixel column inside smiley sprite (0..SPRITE_W-1)
- offsetY  in  11  pixel row inside smiley sprite (0..SPRITE_H-1)
- collisionSmileyBorders  out  1  one-cycle pulse: smiley overlapped a border last frame
- collisionSmileyFlipper  out  1  one-cycle pulse: smiley overlapped flipper last frame
- HitEdgeCode  out  4  [3]=left, [2]=top, [1]=right, [0]=bottom; held until next report

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (resetN). On reset:
  - all outputs are 0;
  - accumulators accBorder, accFlipper and accEdge[3:0] are 0;
  - the holdoff counter is 0;
  - the FSM is in ACCUM.
- Reset mid-frame discards the partial frame; nothing is reported for it.
- Edge classification (combinational, per pixel): left = offsetX < EDGE_MARGIN; right = offsetX >= SPRITE_W-EDGE_MARGIN; top = offsetY < EDGE_MARGIN; bottom = offsetY >= SPRITE_H-EDGE_MARGIN.
  - Corner pixels set two bits.
  - Interior pixels set no bits.
- Border overlap = smileyDR && bordersDR. Flipper overlap = smileyDR && flipperDR.
- FSM states: ACCUM, REPORT.
- ACCUM:
  - On each cycle with a border overlap, set accBorder and OR the edge bits into accEdge.
  - On each cycle with a flipper overlap, set accFlipper.
  - On startOfFrame, snapshot the accumulators into report registers, clear the accumulators, and go to REPORT.
  - A pixel overlap in the same cycle as startOfFrame counts toward the NEW frame.
- REPORT (exactly 1 cycle):
  - collisionSmileyBorders = snapshot accBorder; collisionSmileyFlipper = snapshot accFlipper.
  - If the border pulse fires, HitEdgeCode is loaded with the snapshot accEdge. Otherwise HitEdgeCode keeps its previous value.
  - Accumulation for the new frame continues in this cycle.
  - Return to ACCUM.
- Latency: pulses are asserted in the cycle after startOfFrame. Both pulses may assert together.
- A border hit on interior pixels only gives a pulse with HitEdgeCode = 4'b0000.
- pause=1:
  - accumulators are held cleared;
  - startOfFrame is ignored (no REPORT);
  - outputs pulse 0 and HitEdgeCode is held.
  - If pause rises while in REPORT, that report cycle still completes.
- offsetX/offsetY are only meaningful when smileyDR=1; they are ignored otherwise.

Optional Feature:
- Macro: COLLISION_HOLDOFF_EN.
- Defined: after a border pulse, a 4-bit holdoff counter loads HOLDOFF_FRAMES.
  - Each later startOfFrame decrements the counter while it is nonzero.
  - A REPORT with counter nonzero suppresses the border pulse and leaves HitEdgeCode unchanged.
  - The flipper pulse is never suppressed.
  - The counter clears on reset and holds during pause.
- Undefined: no counter; every frame with a border overlap reports.

Decomposition:
- Package collision_pkg:
  - edge bit indices EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0;
  - FSM enum state_t {ACCUM, REPORT}.
- The motion controller imports the same edge indices.
- One natural sub-module: edge_classifier (pure combinational offset-to-4-bit edge mapping), reused by future objects.

Test Plan:
1. Reset then idle frame: no overlaps, startOfFrame -> both pulses 0, HitEdgeCode=0000.
2. Bottom hit: border overlap at offset (16,30), next startOfFrame -> collisionSmileyBorders=1 for exactly 1 cycle after startOfFrame, HitEdgeCode=0001, held through the next empty frame.
3. Corner plus flipper: border overlap at (1,1) and flipper overlap at (10,31) in one frame -> both pulses in the same cycle, HitEdgeCode=1100.
4. Boundary: overlap at (0,16) coincident with startOfFrame -> no pulse in that report; left pulse (1000) at the following frame.
5. Pause: overlaps with pause=1 across 3 frames -> no pulses. Unpause, overlap at (31,16) -> pulse with HitEdgeCode=0010.
6. COLLISION_HOLDOFF_EN with HOLDOFF_FRAMES=2: border overlap every frame -> border pulses on frames 1 and 4 only. Flipper overlap every frame -> flipper pulses every frame.
